multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control unit for the multicycle MIPS datapath, and the producer of the 4-bit AluOp code that the ALU consumes. It is a Moore FSM that sequences fetch, decode, execute, memory and writeback for each instruction. From the latched opcode and funct it drives every datapath enable and mux select, and it combines the ALU zero flag into the PC write enable.

## Interface
- No parameters.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- Opcode  in  6  IR[31:26]; valid from the DECODE state onward.
- Funct  in  6  IR[5:0]; valid from the DECODE state onward.
- zero  in  1  ALU zero flag.
- PCEn  out  1  PC write enable; equals PCWrite | (branch state & zero).
- IorD  out  1  memory address select; 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  register write address; 1 = rd, 0 = rt.
- MemtoReg  out  1  register write data; 1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A input; 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B input; 00 = register B, 01 = constant 4, 10 = extended immediate, 11 = immediate<<2.
- ZeroExt  out  1  immediate extension; 1 = zero-extend, 0 = sign-extend.
- PCSource  out  2  next PC; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- AluOp  out  4  ALU operation code.
- Illegal  out  1  one-cycle pulse in DECODE when the opcode or funct is unsupported.
- State  out  4  current state, for debug.

## Operation
- AluOp encoding. AluOp[2] = 0 selects the arithmetic unit, AluOp[2] = 1 selects the logic unit.
  - Arithmetic: 0000 add, 0001 sub, 0011 slt.
  - Logic: 0100 and, 0101 or, 0110 nor, 0111 xor.
- Supported opcodes:
  - R-type 000000, with funct 100000 add, 100010 sub, 101010 slt, 100100 and, 100101 or, 100111 nor, 100110 xor.
  - lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101.
- Opcode and Funct are sampled into internal registers on the clock edge leaving DECODE. All later states use only the latched copies.
- State encoding and outputs. Any output not listed is 0; AluOp defaults to 0000.
  - FETCH (0): IRWrite = 1, ALUSrcB = 01, AluOp = add, PCWrite = 1 (PCSource = 00).
  - DECODE (1): ALUSrcB = 11, AluOp = add; computes the branch target.
  - MEMADR (2): ALUSrcA = 1, ALUSrcB = 10, AluOp = add.
  - MEMRD (3): IorD = 1.
  - MEMWB (4): RegWrite = 1, MemtoReg = 1, RegDst = 0.
  - MEMWR (5): IorD = 1, MemWrite = 1.
  - EXEC (6): ALUSrcA = 1, ALUSrcB = 00, AluOp decoded from the latched funct.
  - ALUWB (7): RegWrite = 1, RegDst = 1.
  - BRANCH (8): ALUSrcA = 1, AluOp = sub, PCSource = 01; PCEn = zero.
  - IMMEX (9): ALUSrcA = 1, ALUSrcB = 10; AluOp = add for addi, and for andi, or for ori; ZeroExt = 1 for andi and ori.
  - IMMWB (10): RegWrite = 1, RegDst = 0.
  - JUMP (11): PCSource = 10, PCWrite = 1.
- Transitions:
  - FETCH goes to DECODE.
  - DECODE goes to MEMADR for lw/sw, EXEC for R-type, BRANCH for beq, JUMP for j, IMMEX for addi/andi/ori.
  - MEMADR goes to MEMRD for lw, MEMWR for sw.
  - MEMRD goes to MEMWB.
  - EXEC goes to ALUWB.
  - IMMEX goes to IMMWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, IMMWB and JUMP all go to FETCH.
- Illegal instruction: unsupported opcode, or R-type with unsupported funct. Illegal pulses in DECODE and the next state is FETCH. No register or memory write occurs.
- State codes 12-15 are unreachable. If entered, the next state is FETCH and all enables are 0.

## Timing
- Reset: while rst_n = 0, State = FETCH and every enable (PCEn, MemWrite, IRWrite, RegWrite) is forced to 0. All selects are 0, AluOp = 0000, Illegal = 0.
- rst_n asserting mid-instruction aborts it immediately. A write enable that is high drops in the same cycle, with no wait for a clock edge.
- Release: the first rising edge with rst_n = 1 executes FETCH.
- All outputs are combinational from State and the latched fields, except PCEn, which also depends combinationally on zero in BRANCH.
- Cycles per instruction, counted FETCH through the last state:
  - beq 3, j 3.
  - R-type 4, sw 4, addi/andi/ori 4.
  - lw 5.
  - Illegal instruction 2.
- Opcode/Funct changes after DECODE, caused by IRWrite in the following FETCH, must not affect the instruction in progress.

## Test plan
- Reset, then Opcode = 000000, Funct = 100111. Required states 0, 1, 6, 7, 0; AluOp = 0110 in EXEC; RegWrite = 1 and RegDst = 1 in ALUWB only.
- lw (100011). Required states 0, 1, 2, 3, 4; IorD = 1 in MEMRD; MemtoReg = 1 and RegWrite = 1 in MEMWB; 5 cycles total.
- beq with zero = 1, then beq with zero = 0 in BRANCH. Required PCEn = 1 and then PCEn = 0 in BRANCH; AluOp = 0001 in both.
- ori (001101). Required ZeroExt = 1 and AluOp = 0101 in IMMEX; RegDst = 0 and RegWrite = 1 in IMMWB.
- Opcode 111111, then R-type with Funct 000000. Required Illegal = 1 for one cycle in DECODE, next state FETCH, no write enable asserted at any point.
- sw (101011), with rst_n driven low while in MEMWR. Required MemWrite falls to 0 asynchronously and State = 0; after release, FETCH executes with IRWrite = 1.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// A Moore machine that sequences fetch/decode/execute/memory/writeback and
// drives every datapath enable, mux select and the 4-bit ALU operation code.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ZeroExt,
  output logic [1:0] PCSource,
  output logic [3:0] AluOp,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StImmEx  = 4'd9,
    StImmWb  = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluSlt = 4'b0011;
  localparam logic [3:0] AluAnd = 4'b0100;
  localparam logic [3:0] AluOr  = 4'b0101;
  localparam logic [3:0] AluNor = 4'b0110;
  localparam logic [3:0] AluXor = 4'b0111;

  state_e     r_state;
  state_e     w_next;
  logic [5:0] r_op;
  logic [5:0] r_funct;

  logic       w_funct_ok;
  logic [3:0] w_exec_aluop;
  logic       w_pcwrite;
  logic       w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg, w_regwrite;
  logic       w_alusrca, w_zeroext, w_illegal, w_branch;
  logic [1:0] w_alusrcb, w_pcsource;
  logic [3:0] w_aluop;

  // State register; Opcode/Funct are captured on the edge leaving DECODE so
  // IR reloads in the following FETCH cannot disturb the instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StFetch;
      r_op    <= '0;
      r_funct <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == StDecode) begin
        r_op    <= Opcode;
        r_funct <= Funct;
      end
    end
  end

  // Supported R-type funct check on the live Funct, used only in DECODE.
  always_comb begin
    w_funct_ok = 1'b0;
    case (Funct)
      6'b100000, 6'b100010, 6'b101010, 6'b100100,
      6'b100101, 6'b100111, 6'b100110: w_funct_ok = 1'b1;
      default:                         w_funct_ok = 1'b0;
    endcase
  end

  // ALU operation for R-type execution, from the latched funct.
  always_comb begin
    w_exec_aluop = AluAdd;
    case (r_funct)
      6'b100000: w_exec_aluop = AluAdd;
      6'b100010: w_exec_aluop = AluSub;
      6'b101010: w_exec_aluop = AluSlt;
      6'b100100: w_exec_aluop = AluAnd;
      6'b100101: w_exec_aluop = AluOr;
      6'b100111: w_exec_aluop = AluNor;
      6'b100110: w_exec_aluop = AluXor;
      default:   w_exec_aluop = AluAdd;
    endcase
  end

  // Next-state and raw Moore outputs; everything defaults to 0 / FETCH.
  always_comb begin
    w_next     = StFetch;
    w_pcwrite  = 1'b0;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_zeroext  = 1'b0;
    w_pcsource = 2'b00;
    w_aluop    = AluAdd;
    w_illegal  = 1'b0;
    w_branch   = 1'b0;
    case (r_state)
      StFetch: begin
        w_irwrite = 1'b1;
        w_alusrcb = 2'b01;
        w_pcwrite = 1'b1;
        w_next    = StDecode;
      end
      StDecode: begin
        w_alusrcb = 2'b11;
        case (Opcode)
          OpLw, OpSw:               w_next = StMemAdr;
          OpBeq:                    w_next = StBranch;
          OpJ:                      w_next = StJump;
          OpAddi, OpAndi, OpOri:    w_next = StImmEx;
          OpRtype: begin
            if (w_funct_ok) w_next = StExec;
            else            w_illegal = 1'b1;
          end
          default:                  w_illegal = 1'b1;
        endcase
      end
      StMemAdr: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (r_op == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        w_iord = 1'b1;
        w_next = StMemWb;
      end
      StMemWb: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
      end
      StMemWr: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      StExec: begin
        w_alusrca = 1'b1;
        w_aluop   = w_exec_aluop;
        w_next    = StAluWb;
      end
      StAluWb: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
      end
      StBranch: begin
        w_alusrca  = 1'b1;
        w_aluop    = AluSub;
        w_pcsource = 2'b01;
        w_branch   = 1'b1;
      end
      StImmEx: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = StImmWb;
        if (r_op == OpAndi) begin
          w_aluop   = AluAnd;
          w_zeroext = 1'b1;
        end else if (r_op == OpOri) begin
          w_aluop   = AluOr;
          w_zeroext = 1'b1;
        end
      end
      StImmWb: begin
        w_regwrite = 1'b1;
      end
      StJump: begin
        w_pcsource = 2'b10;
        w_pcwrite  = 1'b1;
      end
      default: w_next = StFetch;
    endcase
  end

  // Reset gates all outputs combinationally so enables drop without a clock.
  always_comb begin
    PCEn     = rst_n & (w_pcwrite | (w_branch & zero));
    IorD     = rst_n & w_iord;
    MemWrite = rst_n & w_memwrite;
    IRWrite  = rst_n & w_irwrite;
    RegDst   = rst_n & w_regdst;
    MemtoReg = rst_n & w_memtoreg;
    RegWrite = rst_n & w_regwrite;
    ALUSrcA  = rst_n & w_alusrca;
    ALUSrcB  = rst_n ? w_alusrcb : 2'b00;
    ZeroExt  = rst_n & w_zeroext;
    PCSource = rst_n ? w_pcsource : 2'b00;
    AluOp    = rst_n ? w_aluop : 4'b0000;
    Illegal  = rst_n & w_illegal;
    State    = r_state;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and checks outputs against hand-derived values.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       zero;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, ZeroExt, Illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] AluOp, State;

  int n_total;
  int n_bad;

  multicycle_control u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Opcode   (Opcode),
    .Funct    (Funct),
    .zero     (zero),
    .PCEn     (PCEn),
    .IorD     (IorD),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ZeroExt  (ZeroExt),
    .PCSource (PCSource),
    .AluOp    (AluOp),
    .Illegal  (Illegal),
    .State    (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample shortly after the inactive edge.
  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    Opcode  = 6'b000000;
    Funct   = 6'b100111;
    zero    = 1'b0;
    #1;
    check_eq("rst_state", State, 0);
    check_eq("rst_irwrite", IRWrite, 0);
    check_eq("rst_pcen", PCEn, 0);
    check_eq("rst_alusrcb", ALUSrcB, 0);
    check_eq("rst_aluop", AluOp, 0);

    // Release: first state is FETCH with its outputs live.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("fetch_state", State, 0);
    check_eq("fetch_irwrite", IRWrite, 1);
    check_eq("fetch_pcen", PCEn, 1);
    check_eq("fetch_alusrcb", ALUSrcB, 2'b01);

    // R-type nor
    next_cyc();
    check_eq("nor_decode", State, 1);
    check_eq("nor_dec_illegal", Illegal, 0);
    check_eq("nor_dec_alusrcb", ALUSrcB, 2'b11);
    check_eq("nor_dec_regwrite", RegWrite, 0);
    next_cyc();
    check_eq("nor_exec", State, 6);
    Funct = 6'b100000;  // IR changes must not leak into the latched funct
    #1;
    check_eq("nor_exec_aluop", AluOp, 4'b0110);
    check_eq("nor_exec_srca", ALUSrcA, 1);
    check_eq("nor_exec_regwrite", RegWrite, 0);
    next_cyc();
    check_eq("nor_aluwb", State, 7);
    check_eq("nor_aluwb_regwrite", RegWrite, 1);
    check_eq("nor_aluwb_regdst", RegDst, 1);
    next_cyc();
    check_eq("nor_back_fetch", State, 0);
    check_eq("nor_fetch_regwrite", RegWrite, 0);

    // lw: 5 cycles
    Opcode = 6'b100011;
    next_cyc();
    check_eq("lw_decode", State, 1);
    next_cyc();
    check_eq("lw_memadr", State, 2);
    check_eq("lw_memadr_srcb", ALUSrcB, 2'b10);
    next_cyc();
    check_eq("lw_memrd", State, 3);
    check_eq("lw_memrd_iord", IorD, 1);
    next_cyc();
    check_eq("lw_memwb", State, 4);
    check_eq("lw_memwb_memtoreg", MemtoReg, 1);
    check_eq("lw_memwb_regwrite", RegWrite, 1);
    check_eq("lw_memwb_regdst", RegDst, 0);
    next_cyc();
    check_eq("lw_back_fetch", State, 0);

    // beq taken
    Opcode = 6'b000100;
    zero   = 1'b1;
    next_cyc();
    next_cyc();
    check_eq("beq1_branch", State, 8);
    check_eq("beq1_pcen", PCEn, 1);
    check_eq("beq1_aluop", AluOp, 4'b0001);
    check_eq("beq1_pcsource", PCSource, 2'b01);
    next_cyc();
    check_eq("beq1_back_fetch", State, 0);

    // beq not taken
    zero = 1'b0;
    next_cyc();
    next_cyc();
    check_eq("beq0_branch", State, 8);
    check_eq("beq0_pcen", PCEn, 0);
    check_eq("beq0_aluop", AluOp, 4'b0001);
    next_cyc();
    check_eq("beq0_back_fetch", State, 0);

    // j
    Opcode = 6'b000010;
    next_cyc();
    next_cyc();
    check_eq("j_jump", State, 11);
    check_eq("j_pcsource", PCSource, 2'b10);
    check_eq("j_pcen", PCEn, 1);
    next_cyc();
    check_eq("j_back_fetch", State, 0);

    // ori
    Opcode = 6'b001101;
    next_cyc();
    next_cyc();
    check_eq("ori_immex", State, 9);
    check_eq("ori_zeroext", ZeroExt, 1);
    check_eq("ori_aluop", AluOp, 4'b0101);
    check_eq("ori_srcb", ALUSrcB, 2'b10);
    next_cyc();
    check_eq("ori_immwb", State, 10);
    check_eq("ori_regdst", RegDst, 0);
    check_eq("ori_regwrite", RegWrite, 1);
    next_cyc();
    check_eq("ori_back_fetch", State, 0);

    // addi: sign-extend, add
    Opcode = 6'b001000;
    next_cyc();
    next_cyc();
    check_eq("addi_immex", State, 9);
    check_eq("addi_zeroext", ZeroExt, 0);
    check_eq("addi_aluop", AluOp, 4'b0000);
    next_cyc();
    next_cyc();

    // illegal opcode
    Opcode = 6'b111111;
    next_cyc();
    check_eq("ill_op_decode", State, 1);
    check_eq("ill_op_pulse", Illegal, 1);
    check_eq("ill_op_wr", {RegWrite, MemWrite}, 0);
    next_cyc();
    check_eq("ill_op_fetch", State, 0);
    check_eq("ill_op_pulse_end", Illegal, 0);

    // illegal funct
    Opcode = 6'b000000;
    Funct  = 6'b000000;
    next_cyc();
    check_eq("ill_fn_decode", State, 1);
    check_eq("ill_fn_pulse", Illegal, 1);
    check_eq("ill_fn_wr", {RegWrite, MemWrite}, 0);
    next_cyc();
    check_eq("ill_fn_fetch", State, 0);
    check_eq("ill_fn_pulse_end", Illegal, 0);

    // sw, reset asserted mid-MEMWR
    Opcode = 6'b101011;
    next_cyc();
    next_cyc();
    check_eq("sw_memadr", State, 2);
    next_cyc();
    check_eq("sw_memwr", State, 5);
    check_eq("sw_memwrite", MemWrite, 1);
    check_eq("sw_iord", IorD, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("sw_rst_memwrite", MemWrite, 0);
    check_eq("sw_rst_state", State, 0);
    check_eq("sw_rst_irwrite", IRWrite, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("sw_rel_state", State, 0);
    check_eq("sw_rel_irwrite", IRWrite, 1);
    next_cyc();
    check_eq("sw_rel_decode", State, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Safety net so the bench cannot hang.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
